// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed driver for a 4-digit seven-segment display.
// Each digit is driven for TICK_DIV cycles, separated by BLANK_CYC cycles with
// every digit off. New display data is loaded through a one-deep shadow
// register. That register is committed only at a frame boundary, so a frame
// never mixes old and new data.
// Every output is registered. The output registers are loaded from the
// next-state values, so the outputs line up with the FSM state they belong to.
module led_scan_ctrl #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        ready,
  input  logic        lz_blank,
  output logic [3:0]  N,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    BLANK_LAST = 8'(BLANK_CYC - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_dig;
  logic [7:0]    r_blank_cnt;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_act_val;
  logic [3:0]    r_act_dp;
  logic [15:0]   r_sh_val;
  logic [3:0]    r_sh_dp;
  logic          r_pending;

  state_t        w_nxt_state;
  logic [1:0]    w_nxt_dig;
  logic [7:0]    w_nxt_blank_cnt;
  logic [PW-1:0] w_nxt_presc;
  logic [15:0]   w_nxt_act_val;
  logic [3:0]    w_nxt_act_dp;
  logic          w_nxt_pending;
  logic          w_frame_end;
  logic          w_accept;
  logic          w_commit;
  logic [3:0]    w_nxt_nib;
  logic          w_nxt_blanked;
  logic          w_nxt_show;
  logic [3:0]    w_nxt_an;
  logic          w_nxt_dp_out;
  logic          w_nxt_frame_done;

  // Next-state, load/commit handshake and the output values for the next cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_nxt_state     = r_state;
    w_nxt_dig       = r_dig;
    w_nxt_blank_cnt = r_blank_cnt;
    w_nxt_presc     = r_presc;

    w_frame_end = (r_state == S_DRIVE) && (r_dig == 2'd3) && (r_presc == PRESC_LAST);
    w_accept    = load && ready;
    w_commit    = w_frame_end && r_pending;

    case (r_state)
      S_BLANK: begin
        if (r_blank_cnt == BLANK_LAST) begin
          w_nxt_state     = S_DRIVE;
          w_nxt_blank_cnt = 8'd0;
          w_nxt_presc     = '0;
        end else begin
          w_nxt_blank_cnt = r_blank_cnt + 8'd1;
        end
      end
      S_DRIVE: begin
        if (r_presc == PRESC_LAST) begin
          w_nxt_state     = S_BLANK;
          w_nxt_dig       = r_dig + 2'd1;
          w_nxt_blank_cnt = 8'd0;
          w_nxt_presc     = '0;
        end else begin
          w_nxt_presc = r_presc + PW'(1);
        end
      end
      default: w_nxt_state = S_BLANK;
    endcase

    // Active data changes only at the frame boundary, taken from the shadow.
    w_nxt_act_val = w_commit ? r_sh_val : r_act_val;
    w_nxt_act_dp  = w_commit ? r_sh_dp  : r_act_dp;

    // Accept and commit never coincide: accepting needs ready, i.e. !pending.
    if (w_accept)      w_nxt_pending = 1'b1;
    else if (w_commit) w_nxt_pending = 1'b0;
    else               w_nxt_pending = r_pending;

    // A digit is a leading zero when it and every digit above it are zero.
    w_nxt_nib     = w_nxt_act_val[{w_nxt_dig, 2'b00} +: 4];
    w_nxt_blanked = lz_blank && (w_nxt_dig != 2'd0) &&
                    ((w_nxt_act_val >> {w_nxt_dig, 2'b00}) == 16'd0);
    w_nxt_show    = (w_nxt_state == S_DRIVE) && !w_nxt_blanked;
    w_nxt_an      = w_nxt_show ? ~(4'b0001 << w_nxt_dig) : 4'b1111;
    w_nxt_dp_out  = w_nxt_show && w_nxt_act_dp[w_nxt_dig];

    w_nxt_frame_done = (w_nxt_state == S_DRIVE) && (w_nxt_dig == 2'd3) &&
                       (w_nxt_presc == PRESC_LAST);
  end

  // Scan FSM state, data registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_BLANK;
      r_dig       <= 2'd0;
      r_blank_cnt <= 8'd0;
      r_presc     <= '0;
      r_act_val   <= 16'd0;
      r_act_dp    <= 4'd0;
      r_sh_val    <= 16'd0;
      r_sh_dp     <= 4'd0;
      r_pending   <= 1'b0;
      ready       <= 1'b1;
      an          <= 4'b1111;
      N           <= 4'd0;
      dp          <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_nxt_state;
      r_dig       <= w_nxt_dig;
      r_blank_cnt <= w_nxt_blank_cnt;
      r_presc     <= w_nxt_presc;
      r_act_val   <= w_nxt_act_val;
      r_act_dp    <= w_nxt_act_dp;
      if (w_accept) begin
        r_sh_val <= val;
        r_sh_dp  <= dp_in;
      end
      r_pending   <= w_nxt_pending;
      ready       <= ~w_nxt_pending;
      an          <= w_nxt_an;
      N           <= w_nxt_nib;
      dp          <= w_nxt_dp_out;
      frame_done  <= w_nxt_frame_done;
    end
  end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000: number of clk cycles each digit is driven (DRIVE dwell), legal range 2..2^20.
REQ-002 The block SHALL have parameter BLANK_CYC, default 4: number of clk cycles all digits are off between digits (anti-ghosting), legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port val, input, 16 bits: four hex digits to display; digit k = val[4k+3:4k], digit 0 least significant.
REQ-006 The block SHALL have port dp_in, input, 4 bits: decimal-point request per digit, bit k = digit k.
REQ-007 The block SHALL have port load, input, 1 bit: request to capture val/dp_in.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-009 The block SHALL have port lz_blank, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-010 The block SHALL have port N, output, 4 bits: nibble fed to the LED seven-segment decoder.
REQ-011 The block SHALL have port an, output, 4 bits: active-low digit enables, bit k = digit k.
REQ-012 The block SHALL have port dp, output, 1 bit: active-high decimal point for the current digit.
REQ-013 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 The FSM SHALL have two states: BLANK and DRIVE; a 2-bit digit index dig selects the digit and wraps 3 -> 0.
REQ-015 In BLANK, an SHALL be 4'b1111 and dp 0; after exactly BLANK_CYC cycles in BLANK the FSM SHALL enter DRIVE.
REQ-016 In DRIVE, an SHALL have only bit dig low, except when that digit is blanked per REQ-019, in which case an = 4'b1111.
REQ-017 DRIVE SHALL last exactly TICK_DIV cycles, timed by a prescaler cleared on DRIVE entry; on its last cycle the FSM SHALL go to BLANK with dig <= dig+1 mod 4.
REQ-018 N SHALL equal the active nibble of dig in both states, so the decoder settles during BLANK; dp SHALL equal active_dp[dig] in DRIVE when not blanked, else 0.
REQ-019 With lz_blank=1, digit k (k = 1..3) SHALL be blanked when active nibbles k..3 are all zero; digit 0 is never blanked.
REQ-020 One frame SHALL be 4*(TICK_DIV+BLANK_CYC) cycles; frame_done SHALL pulse high for one cycle on the DRIVE -> BLANK transition of dig=3.
REQ-021 Load handshake: when load=1 and ready=1, val/dp_in SHALL be captured into a shadow register, a pending flag set, and ready SHALL be 0 from the next cycle.
REQ-022 load while ready=0 SHALL be ignored with no effect on shadow or active data.
REQ-023 At the frame_done cycle with pending=1, the shadow SHALL be copied to the active registers, pending cleared and ready SHALL return to 1 next cycle; the display therefore never changes mid-frame.
REQ-024 A load accepted in the same cycle as a frame_done with pending=0 SHALL be committed at the following frame end, not the current one.

Reset
REQ-025 While rst=1 at a clk edge: state=BLANK, dig=0, blank counter and prescaler=0, active value=0, active_dp=0, shadow=0, pending=0; outputs an=4'b1111, N=0, dp=0, ready=1, frame_done=0.
REQ-026 rst asserted mid-frame SHALL discard any pending load, produce no frame_done, and restart at BLANK of digit 0.

Verification (TICK_DIV=4, BLANK_CYC=2, frame = 24 cycles)
REQ-027 Reset: rst high 2 cycles, then low -> an=1111, ready=1 for 2 cycles, then an=1110, N=0 for 4 cycles.
REQ-028 Load val=16'h1234, dp_in=4'b0010 with ready=1 -> ready=0 next cycle; after the next frame_done, N = 4,3,2,1 with an = 1110,1101,1011,0111 (4 cycles each, 2 cycles of 1111 between); dp=1 only on digit 1; ready=1.
REQ-029 lz_blank=1: val=16'h0005 -> only digit 0 driven (an=1110, N=5), other slots an=1111; val=16'h0000 -> digit 0 shows N=0.
REQ-030 Load 16'hFFFF while ready=0 after a pending 16'h1234 -> ignored; 16'h1234 is committed.
REQ-031 rst pulsed during DRIVE of digit 2 with a load pending -> next cycle an=1111, ready=1, active value 0, no frame_done.
REQ-032 Free-run 5 frames -> frame_done is high exactly 1 cycle every 24 cycles, coincident with the digit 3 -> 0 wrap.
